// File: rtl/run_detect_sched.sv
// Two-requester round-robin scheduler feeding a "11" run detector (Q0/Q1/Q2 Moore FSM).
// A granted word is shifted out MSB-first; count tallies detector cycles that end in Q2.
module run_detect_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             run,
  output logic             done,
  output logic             done_id,
  output logic [3:0]       count
);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_t;
  typedef enum logic [1:0] {Q0, Q1, Q2} det_t;

  ctrl_t            state;
  det_t             det;
  det_t             det_nxt;
  logic [WIDTH-1:0] sreg;
  logic [3:0]       bit_cnt;
  logic             owner;
  logic             last_served;
  logic             winner;
  logic             w;

  always_comb begin
    w       = sreg[WIDTH-1];
    det_nxt = Q0;
    if (w) begin
      case (det)
        Q0:      det_nxt = Q1;
        default: det_nxt = Q2;
      endcase
    end
  end

  // Contention goes to whichever requester was not served last.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      det         <= Q0;
      sreg        <= '0;
      bit_cnt     <= '0;
      owner       <= 1'b0;
      last_served <= 1'b1;
      gnt         <= '0;
      busy        <= 1'b0;
      run         <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      count       <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            owner   <= winner;
            sreg    <= winner ? data1 : data0;
            gnt     <= winner ? 2'b10 : 2'b01;
            count   <= '0;
            det     <= Q0;
            run     <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          det     <= det_nxt;
          run     <= (det_nxt == Q2);
          sreg    <= {sreg[WIDTH-2:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
          if (det_nxt == Q2 && count != 4'hF)
            count <= count + 4'd1;
          if (bit_cnt == 4'(WIDTH - 1)) begin
            state   <= REPORT;
            done    <= 1'b1;
            done_id <= owner;
          end
        end
        REPORT: begin
          last_served <= owner;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: transaction-level model compared every cycle, plus directed literals.
module tb_run_detect_sched;
  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [WIDTH-1:0] data0, data1;
  logic [1:0]       gnt;
  logic             busy, run, done, done_id;
  logic [3:0]       count;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  bit started = 1'b0;

  run_detect_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .busy(busy), .run(run), .done(done), .done_id(done_id), .count(count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Model: m_t = edges since grant (-1 when idle); m_s = bits shifted out of m_word so far.
  int               m_t = -1;
  int               m_s = 0;
  logic [WIDTH-1:0] m_word = '0;
  logic             m_owner = 1'b0;
  logic             m_last = 1'b1;
  logic             m_done_id = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_t = -1; m_s = 0; m_word = '0; m_owner = 1'b0; m_last = 1'b1; m_done_id = 1'b0;
    end else if (m_t < 0) begin
      if (req != 2'b00) begin
        m_owner = (req == 2'b11) ? ~m_last : (req == 2'b10);
        m_word  = m_owner ? data1 : data0;
        m_t     = 0;
        m_s     = 0;
      end
    end else begin
      m_t++;
      if (m_t <= int'(WIDTH)) m_s = m_t;
      if (m_t == int'(WIDTH)) m_done_id = m_owner;
      if (m_t == int'(WIDTH) + 1) begin
        m_last = m_owner;
        m_t    = -1;
      end
    end
  end

  function automatic logic scan_bit(input int i);
    return m_word[WIDTH-1-i];
  endfunction

  // Detector sits in Q2 exactly when the last two scanned bits were both 1.
  function automatic logic [3:0] exp_count();
    int c = 0;
    for (int i = 1; i < m_s; i++) if (scan_bit(i) && scan_bit(i-1)) c++;
    return (c > 15) ? 4'hF : 4'(c);
  endfunction

  function automatic logic exp_run();
    return (m_s >= 2) && scan_bit(m_s-1) && scan_bit(m_s-2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic [9:0] e, a;
      e = {(m_t == 0) ? (m_owner ? 2'b10 : 2'b01) : 2'b00, m_t >= 0, exp_run(),
           m_t == int'(WIDTH), m_done_id, exp_count()};
      a = {gnt, busy, run, done, done_id, count};
      check("cycle_outputs{gnt,busy,run,done,done_id,count}", 32'(a), 32'(e));
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    @(negedge clk);
    while (gnt === 2'b00 && n < budget) begin @(negedge clk); n++; end
    check("gnt_seen", 32'(gnt != 2'b00), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
  endtask

  int g_first, g_second;

  initial begin
    reset = 1'b1; req = '0; data0 = '0; data1 = '0;
    repeat (2) @(negedge clk);
    started = 1'b1;
    check("reset_outputs", 32'({gnt, busy, run, done, done_id, count}), 32'd0);
    #1 reset = 1'b0;

    // Single requester 0, word 11101100 -> count 3
    @(negedge clk); req = 2'b01; data0 = 8'b11101100;
    @(negedge clk);
    check("t29_gnt", 32'(gnt), 32'd1);
    req = 2'b00;
    wait_done(20);
    check("t29_count", 32'(count), 32'd3);
    check("t29_done_id", 32'(done_id), 32'd0);

    // Contention from reset: requester 0 first
    do_reset();
    req = 2'b11; data0 = 8'hFF; data1 = 8'h00;
    wait_gnt(5);
    check("t30_first_gnt", 32'(gnt), 32'd1);
    req = 2'b10;
    wait_done(20);
    check("t30_count0", 32'(count), 32'd7);
    check("t30_id0", 32'(done_id), 32'd0);
    wait_done(20);
    check("t30_count1", 32'(count), 32'd0);
    check("t30_id1", 32'(done_id), 32'd1);
    req = 2'b00;

    // Held req on requester 1, alternating word, back-to-back spacing
    @(negedge clk); req = 2'b10; data1 = 8'b10101010;
    wait_gnt(5); g_first = cycle;
    wait_done(20);
    check("t31_count_a", 32'(count), 32'd0);
    wait_gnt(5); g_second = cycle;
    check("t31_spacing", 32'(g_second - g_first), 32'(WIDTH + 2));
    wait_done(20);
    check("t31_count_b", 32'(count), 32'd0);
    req = 2'b00;

    // Reset mid-scan after shift edge 4
    repeat (3) @(negedge clk);
    req = 2'b01; data0 = 8'hFF;
    wait_gnt(5);
    repeat (4) @(negedge clk);
    #1 reset = 1'b1;
    #1 check("t32_async_reset", 32'({gnt, busy, run, done, done_id, count}), 32'd0);
    @(negedge clk); #1 reset = 1'b0;
    req = 2'b00;
    repeat (3) @(negedge clk);
    req = 2'b01;
    wait_gnt(5);
    req = 2'b00;
    wait_done(20);
    check("t32_count", 32'(count), 32'd7);

    // Data and req changed during SHIFT: latched word governs
    @(negedge clk); req = 2'b01; data0 = 8'b11101100;
    wait_gnt(5);
    req = 2'b00; data0 = 8'hFF; data1 = 8'hFF;
    wait_done(20);
    check("t33_count", 32'(count), 32'd3);
    repeat (4) @(negedge clk);
    check("t33_no_extra_gnt", 32'({gnt, busy}), 32'd0);

    // Randomized traffic with occasional asynchronous reset
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      req   = 2'($urandom);
      data0 = WIDTH'($urandom);
      data1 = WIDTH'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b1;
        @(negedge clk); #1 reset = 1'b0;
      end
    end
    req = 2'b00;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1);
  end

endmodule

// File: doc/run_detect_sched.md
RUN_DETECT_SCHED -- requirements
Module: run_detect_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving bits per scanned word (range 2..15).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  2  per-requester scan request, level, held until granted.
REQ-005 SHALL have port data0  input  WIDTH  word from requester 0, sampled only at grant.
REQ-006 SHALL have port data1  input  WIDTH  word from requester 1, sampled only at grant.
REQ-007 SHALL have port gnt  output  2  one-hot grant pulse, one cycle.
REQ-008 SHALL have port busy  output  1  high while a scan is in progress or reporting.
REQ-009 SHALL have port run  output  1  Moore detector output z, high while the detector is in state Q2.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port done_id  output  1  requester index of the completed scan.
REQ-012 SHALL have port count  output  4  number of detector entries-to-or-stays-in Q2 for the last scan.

Function
REQ-013 SHALL implement controller states IDLE, SHIFT, REPORT, and detector states Q0, Q1, Q2.
REQ-014 IDLE with req==0 SHALL remain in IDLE with no outputs changing.
REQ-015 IDLE with exactly one req bit set SHALL grant that requester at the next edge.
REQ-016 IDLE with req==2'b11 SHALL grant the requester not served last (round-robin); after reset, last-served=1, so requester 0 wins first.
REQ-017 On a grant edge SHALL: load the winner's data into the shift register, set owner, assert gnt[owner] for the following cycle only, clear count, set detector to Q0 and bit counter to 0, and enter SHIFT.
REQ-018 In SHIFT, each edge SHALL feed w = shift-register MSB to the detector, shift the register left by one, and increment the bit counter.
REQ-019 Detector transitions SHALL be: Q0 -w-> Q1; Q1 -w-> Q2; Q2 -w-> Q2; any state -!w-> Q0; run=1 only in Q2.
REQ-020 count SHALL increment on every SHIFT edge whose next detector state is Q2, saturating at 15.
REQ-021 After the WIDTH-th shift edge, the controller SHALL enter REPORT; done=1, done_id=owner for that one cycle; then set last-served=owner and return to IDLE.
REQ-022 Latency SHALL be: grant edge E0, shifts at E1..E_WIDTH, done high in the cycle after E_WIDTH, IDLE after E_WIDTH+1; the earliest next grant occurs at edge E_WIDTH+2.
REQ-023 busy SHALL be 1 in SHIFT and REPORT, and 0 in IDLE.
REQ-024 count and done_id SHALL hold their values from REPORT until the next grant edge.
REQ-025 Changes to req or data during SHIFT/REPORT SHALL have no effect; a req dropped before grant SHALL be ignored.
REQ-026 The detector SHALL hold its state in IDLE; run therefore reflects the last scan's final state until the next grant.

Reset
REQ-027 reset SHALL immediately force: IDLE, detector Q0, gnt=0, busy=0, run=0, done=0, done_id=0, count=0, last-served=1, shift register and bit counter 0.
REQ-028 reset asserted mid-scan SHALL abort the scan without a done pulse; the requester SHALL re-request.

Verification
REQ-029 req=01, data0=8'b11101100 -> gnt=01 one cycle; done after 9 cycles; count=3, done_id=0.
REQ-030 req=11 from reset, data0=8'hFF, data1=8'h00 -> requester 0 served first with count=7, then requester 1 with count=0, done_id=1.
REQ-031 req=10 held continuously, data1=8'b10101010 -> count=0, run never 1, back-to-back grants at the REPORT+1 spacing.
REQ-032 reset pulsed at shift edge 4 of data0=8'hFF -> all outputs 0 immediately, no done pulse; fresh req=01 later -> count=7.
REQ-033 data changed and req dropped during SHIFT -> count computed from the word latched at grant, no extra grant.
